// File: rtl/ntt_ctrl_pkg.sv
// ntt_ctrl_pkg: shared constants, butterfly mode encodings and sequencer states
package ntt_ctrl_pkg;
    localparam int KEM_Q = 7681;
    localparam logic [1:0] BF_NTT  = 2'd0;
    localparam logic [1:0] BF_INTT = 2'd1;
    localparam logic [1:0] BF_MUL  = 2'd2;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    function automatic logic [1:0] mode_of(input logic inv);
        return inv ? BF_INTT : BF_NTT;
    endfunction
endpackage

// File: rtl/ntt_ctrl_if.sv
// ntt_ctrl_if: control handshake plus coefficient-RAM/butterfly bus of the NTT sequencer
interface ntt_ctrl_if #(parameter int AW = 6);
    logic          start, inv, busy, done;
    logic          rd_en, bf_valid, wr_en;
    logic [AW-1:0] rd_addr0, rd_addr1, zeta_addr, wr_addr0, wr_addr1;
    logic [1:0]    bf_mode;
    modport master (input start, inv,
                    output busy, done, rd_en, rd_addr0, rd_addr1, zeta_addr,
                           bf_mode, bf_valid, wr_en, wr_addr0, wr_addr1);
    modport slave  (output start, inv,
                    input  busy, done, rd_en, rd_addr0, rd_addr1, zeta_addr,
                           bf_mode, bf_valid, wr_en, wr_addr0, wr_addr1);
endinterface

// File: rtl/ntt_ctrl_delay_line.sv
// ntt_ctrl_delay_line: fixed-depth shift register with async active-low clear
module ntt_ctrl_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] sr [DEPTH];
    // shift one stage per cycle, unconditionally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end
    assign q = sr[DEPTH-1];
endmodule

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: walks all NTT/INTT layers, one butterfly per cycle, with drained layer boundaries
module ntt_ctrl
    import ntt_ctrl_pkg::*;
#(
    parameter int N      = 64,
    parameter int LOGN   = 6,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 7,
    parameter int AW     = 6
) (
    input  logic clk,
    input  logic rst_n,
    ntt_ctrl_if.master bus
);
    localparam int D  = RD_LAT + BF_LAT;
    localparam int DW = $clog2(D + 1);
    localparam int LW = $clog2(LOGN + 1);
    localparam logic [AW-1:0] ONE  = AW'(1);
    localparam logic [AW-1:0] HALF = AW'(N / 2);
    localparam logic [AW-1:0] MAXK = AW'(N - 1);

    state_t        state;
    logic          inv_q, wrap;
    logic [AW-1:0] len, j, grp, k, cnt, nj, ngrp, nk, nlen, base;
    logic [DW-1:0] dcnt;
    logic [LW-1:0] layer;
    logic [2*AW:0] wb;

    // index of the following butterfly within the current layer
    always_comb begin
        wrap = j == len - ONE;
        nj   = wrap ? '0 : j + ONE;
        ngrp = wrap ? grp + ONE : grp;
        nk   = wrap ? (inv_q ? k - ONE : k + ONE) : k;
        nlen = inv_q ? len << 1 : len >> 1;
        base = (ngrp * len) << 1;
    end

    // sequencer FSM with registered read-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            inv_q         <= 1'b0;
            len           <= '0;
            j             <= '0;
            grp           <= '0;
            k             <= '0;
            cnt           <= '0;
            dcnt          <= '0;
            layer         <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.rd_en     <= 1'b0;
            bus.rd_addr0  <= '0;
            bus.rd_addr1  <= '0;
            bus.zeta_addr <= '0;
            bus.bf_mode   <= BF_NTT;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    inv_q         <= bus.inv;
                    bus.bf_mode   <= mode_of(bus.inv);
                    len           <= bus.inv ? ONE : HALF;
                    j             <= '0;
                    grp           <= '0;
                    k             <= bus.inv ? MAXK : ONE;
                    cnt           <= '0;
                    layer         <= '0;
                    bus.busy      <= 1'b1;
                    bus.rd_en     <= 1'b1;
                    bus.rd_addr0  <= '0;
                    bus.rd_addr1  <= bus.inv ? ONE : HALF;
                    bus.zeta_addr <= bus.inv ? MAXK : ONE;
                    state         <= ISSUE;
                end
                ISSUE: begin
                    j   <= nj;
                    grp <= ngrp;
                    k   <= nk;
                    cnt <= cnt + ONE;
                    if (cnt == HALF - ONE) begin
                        bus.rd_en <= 1'b0;
                        dcnt      <= DW'(D - 1);
                        state     <= DRAIN;
                    end else begin
                        bus.rd_addr0  <= base + nj;
                        bus.rd_addr1  <= base + nj + len;
                        bus.zeta_addr <= nk;
                    end
                end
                DRAIN: begin
                    dcnt <= dcnt - DW'(1);
                    if (dcnt == '0) begin
                        if (layer == LW'(LOGN - 1)) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            len           <= nlen;
                            j             <= '0;
                            grp           <= '0;
                            cnt           <= '0;
                            layer         <= layer + LW'(1);
                            bus.rd_en     <= 1'b1;
                            bus.rd_addr0  <= '0;
                            bus.rd_addr1  <= nlen;
                            bus.zeta_addr <= k;
                            state         <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    ntt_ctrl_delay_line #(.W(1), .DEPTH(RD_LAT)) u_valid (
        .clk(clk), .rst_n(rst_n), .d(bus.rd_en), .q(bus.bf_valid)
    );

    ntt_ctrl_delay_line #(.W(2 * AW + 1), .DEPTH(D)) u_wb (
        .clk(clk), .rst_n(rst_n), .d({bus.rd_en, bus.rd_addr0, bus.rd_addr1}), .q(wb)
    );

    assign {bus.wr_en, bus.wr_addr0, bus.wr_addr1} = wb;
endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: scoreboard bench for the NTT sequencer (N=64, RD_LAT=1, BF_LAT=7)
module tb_ntt_ctrl;
    typedef struct packed {
        logic       en;
        logic [5:0] a0, a1, z;
    } iss_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0, n_fail = 0;
    iss_t exp_q[$];
    iss_t wq[$];

    always #5 clk = ~clk;

    ntt_ctrl_if #(.AW(6)) bus ();

    ntt_ctrl #(.N(64), .LOGN(6), .RD_LAT(1), .BF_LAT(7), .AW(6)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    function automatic logic [36:0] outs();
        return {bus.busy, bus.done, bus.rd_en, bus.rd_addr0, bus.rd_addr1, bus.zeta_addr,
                bus.bf_mode, bus.bf_valid, bus.wr_en, bus.wr_addr0, bus.wr_addr1};
    endfunction

    // reference issue order: layers of groups of len butterflies, then an 8-cycle drain
    task automatic model(input bit iv);
        int len = iv ? 1 : 32;
        int k   = iv ? 63 : 1;
        iss_t e;
        for (int l = 0; l < 6; l++) begin
            for (int g = 0; g < 32 / len; g++) begin
                for (int jj = 0; jj < len; jj++) begin
                    e.en = 1'b1;
                    e.a0 = 6'(g * 2 * len + jj);
                    e.a1 = 6'(g * 2 * len + jj + len);
                    e.z  = 6'(k);
                    exp_q.push_back(e);
                end
                k = iv ? k - 1 : k + 1;
            end
            repeat (8) exp_q.push_back('0);
            len = iv ? len * 2 : len / 2;
        end
    endtask

    task automatic run(input bit iv, input int poke, input string nm);
        iss_t e, w;
        int   wcnt[64];
        int   wtot = 0, bad = 0;
        logic pv = 1'b0;
        for (int i = 0; i < 64; i++) wcnt[i] = 0;
        exp_q.delete();
        wq.delete();
        model(iv);
        repeat (8) wq.push_back('0);
        bus.inv   = iv;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int t = 0; t < 240; t++) begin
            e = exp_q.pop_front();
            wq.push_back(e);
            w = wq.pop_front();
            n_chk++;
            if (bus.rd_en !== e.en || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s ctl c%0d: rd_en/busy/done=%b%b%b want %b10", nm, t, bus.rd_en, bus.busy, bus.done, e.en);
            end
            if (e.en) begin
                n_chk++;
                if ({bus.rd_addr0, bus.rd_addr1, bus.zeta_addr} !== {e.a0, e.a1, e.z}) begin
                    n_fail++;
                    $display("FAIL %s rd c%0d: a0=%0d a1=%0d z=%0d want %0d %0d %0d", nm, t,
                             bus.rd_addr0, bus.rd_addr1, bus.zeta_addr, e.a0, e.a1, e.z);
                end
                n_chk++;
                if (bus.bf_mode !== {1'b0, iv}) begin
                    n_fail++;
                    $display("FAIL %s bf_mode c%0d: got %0d want %0d", nm, t, bus.bf_mode, iv);
                end
            end
            n_chk++;
            if (bus.bf_valid !== pv) begin
                n_fail++;
                $display("FAIL %s bf_valid c%0d: got %b want %b", nm, t, bus.bf_valid, pv);
            end
            pv = e.en;
            n_chk++;
            if (bus.wr_en !== w.en || (w.en && {bus.wr_addr0, bus.wr_addr1} !== {w.a0, w.a1})) begin
                n_fail++;
                $display("FAIL %s wr c%0d: en=%b a0=%0d a1=%0d want %b %0d %0d", nm, t,
                         bus.wr_en, bus.wr_addr0, bus.wr_addr1, w.en, w.a0, w.a1);
            end
            if (bus.wr_en === 1'b1 && !$isunknown({bus.wr_addr0, bus.wr_addr1})) begin
                wcnt[bus.wr_addr0]++;
                wcnt[bus.wr_addr1]++;
                wtot++;
            end
            bus.start = (t == poke);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        n_chk++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done@240: done/busy/wr_en=%b%b%b want 100", nm, bus.done, bus.busy, bus.wr_en);
        end
        n_chk++;
        if (wtot != 192) begin
            n_fail++;
            $display("FAIL %s wr_count: got %0d want 192", nm, wtot);
        end
        for (int i = 0; i < 64; i++) if (wcnt[i] != 6) bad++;
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s wr_cover: %0d addresses not written 6 times, want 0", nm, bad);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.inv   = 1'b0;
        rst_n     = 1'b1;
        #3 rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h want 0", outs());
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL idle_outs: got %h want 0", outs());
        end
    endtask

    task automatic test_forward();
        run(1'b0, -1, "fwd");
    endtask

    task automatic test_inverse();
        run(1'b1, -1, "inv");
    endtask

    task automatic test_ignore_start();
        run(1'b0, 10, "ign");
        for (int t = 0; t < 20; t++) begin
            n_chk++;
            if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL ign_rerun c%0d: busy=%b rd_en=%b want 0 0", t, bus.busy, bus.rd_en);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        bus.inv   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        n_chk++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: got %b want 1", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL mid_async_clear: got %h want 0", outs());
        end
        repeat (10) @(posedge clk);
        #1;
        n_chk++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL mid_held: got %h want 0", outs());
        end
        @(negedge clk) rst_n = 1'b1;
        run(1'b0, -1, "fwd_after_rst");
    endtask

    task automatic test_back_to_back();
        run(1'b0, -1, "b2b_1");
        run(1'b0, -1, "b2b_2");
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ntt_ctrl.md
Name: ntt_ctrl

Overview:
- Sequencer directly upstream of the butterfly unit.
- Walks all layers of a forward (Cooley-Tukey) or inverse (Gentleman-Sande) NTT over one N-coefficient polynomial, issuing one butterfly per cycle: coefficient-RAM read addresses, zeta-ROM index and mode.
- Delays the write-back addresses to match RAM read latency plus butterfly pipeline depth.
- Drains between layers so a layer never reads a coefficient still in flight.

Parameters:
- N, 64: polynomial length; power of two, >= 4.
- LOGN, 6: log2(N).
- RD_LAT, 1: coefficient-RAM and zeta-ROM read latency, in cycles.
- BF_LAT, 7: butterfly input-to-output latency, in cycles.
- AW, 6: coefficient address width, equal to LOGN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- inv  in  1  0 = forward NTT, 1 = inverse NTT; sampled with start.
- busy  out  1  high from accepted start until done is asserted.
- done  out  1  one-cycle pulse at completion.
- rd_en  out  1  read strobe to the coefficient RAM.
- rd_addr0  out  AW  address of the top operand (index j).
- rd_addr1  out  AW  address of the bottom operand (index j+len).
- zeta_addr  out  AW  zeta-ROM index for the current group.
- bf_mode  out  2  to butterfly mode: 0 forward, 1 inverse; value 2 is never driven.
- bf_valid  out  1  rd_en delayed RD_LAT cycles; marks butterfly input as valid.
- wr_en  out  1  rd_en delayed RD_LAT+BF_LAT cycles.
- wr_addr0  out  AW  rd_addr0 delayed RD_LAT+BF_LAT cycles.
- wr_addr1  out  AW  rd_addr1 delayed RD_LAT+BF_LAT cycles.

Behaviour:
- Reset (async, rst_n=0): state IDLE. Every output 0, all delay-line stages cleared. Reset mid-operation aborts immediately; no pending write completes.
- States and transitions:
  - IDLE: on start=1, latch inv and go to ISSUE. Load len: N/2 if forward, 1 if inverse. Set j=0, grp=0. Set k: 1 if forward, N-1 if inverse.
  - ISSUE: one butterfly per cycle. rd_en=1, rd_addr0 = grp*2*len + j, rd_addr1 = rd_addr0 + len, zeta_addr = k.
    - j increments each cycle. When j = len-1: j wraps to 0, grp increments, and k increments (forward) or decrements (inverse).
    - After exactly N/2 issues, go to DRAIN.
  - DRAIN: rd_en=0 for D = RD_LAT+BF_LAT cycles; a counter runs D down to 0.
    - Then, if this was layer LOGN-1, go to DONE.
    - Otherwise update len (forward len>>1, inverse len<<1), set grp=0, and return to ISSUE.
  - DONE: done=1 for one cycle, busy drops in the same cycle, return to IDLE.
- busy=1 in ISSUE and DRAIN, 0 in IDLE and DONE.
- start while not in IDLE is ignored.
- bf_mode = {1'b0, latched inv}; held constant for the whole operation.
- Delay lines: a shift register of depth RD_LAT carries rd_en to bf_valid. A shift register of depth D carries {rd_en, rd_addr0, rd_addr1} to {wr_en, wr_addr0, wr_addr1}. Both advance every cycle, including in DRAIN.
- The last layer's last write (wr_en) occurs in the final DRAIN cycle. done follows one cycle later.
- Latency: with first issue at cycle 0, done is high at cycle LOGN*(N/2+D). Default: 6*(32+8) = 240.
- Arithmetic: all address arithmetic is AW-bit unsigned. grp*2*len + j is always < N, so no wrap occurs. The zeta index k stays in [1, N-1].

Decomposition:
- Shared package holds: KEM_Q=7681; mode encodings BF_NTT=0, BF_INTT=1, BF_MUL=2; state enum {IDLE, ISSUE, DRAIN, DONE}.
- One sub-module is natural: delay_line (parameterised width and depth, async active-low clear). Instantiate it twice: for bf_valid, and for the write-back bundle.

Test Plan:
- Forward, N=64: start with inv=0.
  - Cycle 0: rd_addr0=0, rd_addr1=32, zeta=1.
  - Cycle 31: rd_addr0=31, rd_addr1=63.
  - Cycles 32-39: rd_en=0.
  - Cycle 40: rd_addr0=0, rd_addr1=16, zeta=2.
  - Cycle 56: rd_addr0=32, rd_addr1=48, zeta=3.
  - done at cycle 240.
- Inverse, N=64: start with inv=1.
  - Cycle 0: rd_addr0=0, rd_addr1=1, zeta=63.
  - Cycle 1: rd_addr0=2, rd_addr1=3, zeta=62.
  - Last layer: pairs (j, j+32), zeta=1. bf_mode=1 throughout.
- Write-back alignment: every wr_addr0/wr_addr1 equals the rd_addr pair issued exactly 8 cycles earlier. Over one run, wr_en is high for exactly 192 cycles, and each address is written once per layer.
- start asserted at cycle 10 while busy -> ignored; done still at cycle 240, with no second run.
- rst_n low at cycle 50 -> all outputs 0 asynchronously. A fresh start after release reproduces the forward sequence from cycle 0.
- Back-to-back: start in the cycle after done -> accepted, and the second run is identical to the first.
